// File: rtl/ir_burst_sequencer.sv
// ============================================================================
// Module   : ir_burst_sequencer
// Purpose  : Walks one IR code record from ROM and gates a PWM carrier for
//            each on/off duration pair.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ir_burst_sequencer #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int PWM_W    = 8,
  parameter int TICK_DIV = 12
) (
  input  logic              clock_in,
  input  logic              reset_n_in,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic [ADDR_W-1:0] start_addr_in,
  output logic              mem_rd_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              pwm_reset_out,
  output logic              pwm_enable_out,
  output logic              pwm_forced_out,
  output logic [PWM_W-1:0]  pwm_compare_out,
  output logic              pwm_update_out,
  output logic              busy_out,
  output logic              done_out,
  output logic [ADDR_W-1:0] next_addr_out
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(TICK_DIV - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH_CAR = 4'd1;
  localparam logic [3:0] S_LOAD      = 4'd2;
  localparam logic [3:0] S_FETCH_CNT = 4'd3;
  localparam logic [3:0] S_FETCH_ON  = 4'd4;
  localparam logic [3:0] S_FETCH_OFF = 4'd5;
  localparam logic [3:0] S_ON        = 4'd6;
  localparam logic [3:0] S_OFF       = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;
  localparam logic [3:0] S_ABORT     = 4'd9;

  logic [3:0]        state_q, state_d;
  logic              ph_q, ph_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [PWM_W-1:0]  car_q, car_d;
  logic [PWM_W-1:0]  loaded_q, loaded_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] on_q, on_d;
  logic [DATA_W-1:0] off_q, off_d;
  logic [DATA_W-1:0] dur_q, dur_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;

  logic       w_fetch;
  logic       w_capture;
  logic       w_tick_end;
  logic       w_last_tick;
  logic       w_pair_end;
  logic [3:0] w_pair_next;

  // Each fetch state spends one issue cycle (ph_q=0) and one capture cycle (ph_q=1).
  assign w_fetch     = (state_q == S_FETCH_CAR) || (state_q == S_FETCH_CNT) ||
                       (state_q == S_FETCH_ON)  || (state_q == S_FETCH_OFF);
  assign w_capture   = w_fetch && ph_q;
  assign w_tick_end  = (pre_q == C_PRE_LAST);
  assign w_last_tick = w_tick_end && (dur_q == DATA_W'(1));
  assign w_pair_next = (rem_q != DATA_W'(1)) ? S_FETCH_ON : S_DONE;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= S_IDLE;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    w_pair_end = 1'b0;
    case (state_q)
      S_IDLE:      if (start_in) state_d = S_FETCH_CAR;
      S_FETCH_CAR: if (ph_q) state_d = S_LOAD;
      S_LOAD:      state_d = S_FETCH_CNT;
      S_FETCH_CNT: if (ph_q) state_d = (mem_data_in == '0) ? S_DONE : S_FETCH_ON;
      S_FETCH_ON:  if (ph_q) state_d = S_FETCH_OFF;
      S_FETCH_OFF: begin
        if (ph_q) begin
          if (on_q != '0) begin
            state_d = S_ON;
          end else if (mem_data_in != '0) begin
            state_d = S_OFF;
          end else begin
            w_pair_end = 1'b1;
            state_d    = w_pair_next;
          end
        end
      end
      S_ON: begin
        if (w_last_tick) begin
          if (off_q != '0) begin
            state_d = S_OFF;
          end else begin
            w_pair_end = 1'b1;
            state_d    = w_pair_next;
          end
        end
      end
      S_OFF: begin
        if (w_last_tick) begin
          w_pair_end = 1'b1;
          state_d    = w_pair_next;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_in && (state_q != S_IDLE) && (state_q != S_ABORT)) begin
      state_d    = S_ABORT;
      w_pair_end = 1'b0;
    end
  end

  always_comb begin
    ph_d        = w_fetch && !ph_q && (state_d == state_q);
    ptr_d       = ptr_q;
    car_d       = car_q;
    loaded_d    = loaded_q;
    rem_d       = rem_q;
    on_d        = on_q;
    off_d       = off_q;
    dur_d       = dur_q;
    pre_d       = pre_q;
    next_addr_d = next_addr_q;

    if ((state_q == S_IDLE) && start_in) ptr_d = start_addr_in;

    if (w_capture) begin
      ptr_d = ptr_q + ADDR_W'(1);
      case (state_q)
        S_FETCH_CAR: car_d = mem_data_in[PWM_W-1:0];
        S_FETCH_CNT: rem_d = mem_data_in;
        S_FETCH_ON:  on_d  = mem_data_in;
        S_FETCH_OFF: off_d = mem_data_in;
        default: ;
      endcase
    end

    if (state_q == S_LOAD) loaded_d = car_q;
    if (w_pair_end) rem_d = rem_q - DATA_W'(1);

    // Prescaler and duration restart on every phase entry so each phase is exact.
    if ((state_d == S_ON) && (state_q != S_ON)) begin
      pre_d = '0;
      dur_d = on_q;
    end else if ((state_d == S_OFF) && (state_q != S_OFF)) begin
      pre_d = '0;
      dur_d = (state_q == S_FETCH_OFF) ? mem_data_in : off_q;
    end else if ((state_q == S_ON) || (state_q == S_OFF)) begin
      if (w_tick_end) begin
        pre_d = '0;
        dur_d = dur_q - DATA_W'(1);
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end

    // The fetch pointer already sits one past the last record word here.
    if ((state_d == S_DONE) && (state_q != S_DONE)) next_addr_d = ptr_d;
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ptr_q       <= '0;
      car_q       <= '0;
      loaded_q    <= '0;
      rem_q       <= '0;
      on_q        <= '0;
      off_q       <= '0;
      dur_q       <= '0;
      pre_q       <= '0;
      next_addr_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      car_q       <= car_d;
      loaded_q    <= loaded_d;
      rem_q       <= rem_d;
      on_q        <= on_d;
      off_q       <= off_d;
      dur_q       <= dur_d;
      pre_q       <= pre_d;
      next_addr_q <= next_addr_d;
    end
  end

  always_comb begin
    mem_rd_out      = w_fetch && !ph_q;
    mem_addr_out    = ptr_q;
    pwm_reset_out   = (state_q == S_ABORT) || ((state_q == S_FETCH_CAR) && !ph_q);
    pwm_enable_out  = (state_q == S_ON);
    pwm_forced_out  = 1'b0;
    pwm_update_out  = (state_q == S_LOAD);
    pwm_compare_out = (state_q == S_LOAD) ? car_q : loaded_q;
    busy_out        = (state_q != S_IDLE);
    done_out        = (state_q == S_DONE);
    next_addr_out   = next_addr_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_ir_burst_sequencer.sv
// ============================================================================
// Module   : tb_ir_burst_sequencer
// Purpose  : Directed and randomized checks of ir_burst_sequencer against a
//            cycle-trace model, on a TICK_DIV=2 and a TICK_DIV=1 instance.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ir_burst_sequencer;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int PW = 8;
  localparam int OW = 35;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] saddr = '0;

  logic          rd2, rst2, en2, frc2, upd2, busy2, done2;
  logic [AW-1:0] addr2, nxt2;
  logic [DW-1:0] data2;
  logic [PW-1:0] cmp2;
  logic          rd1, rst1, en1, frc1, upd1, busy1, done1;
  logic [AW-1:0] addr1, nxt1;
  logic [DW-1:0] data1;
  logic [PW-1:0] cmp1;

  always #5 clk = ~clk;

  ir_burst_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PWM_W(PW), .TICK_DIV(2)) u_td2 (
    .clock_in(clk), .reset_n_in(rst_n), .start_in(start), .abort_in(abort),
    .start_addr_in(saddr), .mem_rd_out(rd2), .mem_addr_out(addr2), .mem_data_in(data2),
    .pwm_reset_out(rst2), .pwm_enable_out(en2), .pwm_forced_out(frc2),
    .pwm_compare_out(cmp2), .pwm_update_out(upd2), .busy_out(busy2),
    .done_out(done2), .next_addr_out(nxt2));

  ir_burst_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PWM_W(PW), .TICK_DIV(1)) u_td1 (
    .clock_in(clk), .reset_n_in(rst_n), .start_in(start), .abort_in(abort),
    .start_addr_in(saddr), .mem_rd_out(rd1), .mem_addr_out(addr1), .mem_data_in(data1),
    .pwm_reset_out(rst1), .pwm_enable_out(en1), .pwm_forced_out(frc1),
    .pwm_compare_out(cmp1), .pwm_update_out(upd1), .busy_out(busy1),
    .done_out(done1), .next_addr_out(nxt1));

  logic [DW-1:0] rom [0:1023];
  always @(posedge clk) begin
    if (rd2) data2 <= rom[addr2];
    if (rd1) data1 <= rom[addr1];
  end

  function automatic logic [OW-1:0] pk(input logic busy, input logic done, input logic rd,
                                       input logic [AW-1:0] a, input logic r, input logic en,
                                       input logic f, input logic upd, input logic [PW-1:0] c,
                                       input logic [AW-1:0] nx);
    return {busy, done, rd, a, r, en, f, upd, c, nx};
  endfunction

  logic [OW-1:0] obs2, obs1;
  assign obs2 = pk(busy2, done2, rd2, addr2, rst2, en2, frc2, upd2, cmp2, nxt2);
  assign obs1 = pk(busy1, done1, rd1, addr1, rst1, en1, frc1, upd1, cmp1, nxt1);

  // Expected per-cycle output trace for each instance (0: TICK_DIV=2, 1: TICK_DIV=1).
  logic [OW-1:0] ev [0:1][0:511];
  logic [OW-1:0] em [0:1][0:511];
  int            elen [0:1];
  logic [PW-1:0] hold_cmp [0:1];
  logic [AW-1:0] hold_nxt [0:1];
  int            bn;
  int            n_assert = 0;
  int            n_fail = 0;
  string         cur_tag = "";

  function automatic void put(input int k, input bit busy, input bit done, input bit rd,
                              input logic [AW-1:0] a, input bit r, input bit en, input bit upd,
                              input logic [PW-1:0] c, input logic [AW-1:0] nx);
    logic [OW-1:0] m;
    m = '1;
    if (!rd) m[31:22] = '0;
    if (busy && !done) m[9:0] = '0;
    if (bn < 512) begin
      ev[k][bn] = pk(busy, done, rd, a, r, en, 1'b0, upd, c, nx);
      em[k][bn] = m;
      bn++;
    end
  endfunction

  // Trace from the record rules: idle, car fetch, load, count fetch, pairs, done, idle.
  function automatic void build(input int k, input int td, input logic [AW-1:0] a,
                                input bit go, input int abort_at);
    logic [PW-1:0] c;
    logic [AW-1:0] nx, p;
    logic [DW-1:0] w;
    int n, on, off;
    bn = 0;
    c  = hold_cmp[k];
    nx = hold_nxt[k];
    put(k, 0, 0, 0, '0, 0, 0, 0, c, nx);
    if (go) begin
      put(k, 1, 0, 1, a, 1, 0, 0, c, nx);
      put(k, 1, 0, 0, '0, 0, 0, 0, c, nx);
      w = rom[a];
      c = w[PW-1:0];
      put(k, 1, 0, 0, '0, 0, 0, 1, c, nx);
      p = a + AW'(1);
      put(k, 1, 0, 1, p, 0, 0, 0, c, nx);
      put(k, 1, 0, 0, '0, 0, 0, 0, c, nx);
      n = int'(rom[p]);
      p = p + AW'(1);
      for (int i = 0; i < n; i++) begin
        put(k, 1, 0, 1, p, 0, 0, 0, c, nx);
        put(k, 1, 0, 0, '0, 0, 0, 0, c, nx);
        on = int'(rom[p]);
        p  = p + AW'(1);
        put(k, 1, 0, 1, p, 0, 0, 0, c, nx);
        put(k, 1, 0, 0, '0, 0, 0, 0, c, nx);
        off = int'(rom[p]);
        p   = p + AW'(1);
        for (int j = 0; j < on * td; j++) put(k, 1, 0, 0, '0, 0, 1, 0, c, nx);
        for (int j = 0; j < off * td; j++) put(k, 1, 0, 0, '0, 0, 0, 0, c, nx);
      end
      put(k, 1, 1, 0, '0, 0, 0, 0, c, p);
      put(k, 0, 0, 0, '0, 0, 0, 0, c, p);
      if (abort_at >= 1 && abort_at + 1 < bn) begin
        c  = ev[k][abort_at][17:10];
        bn = abort_at + 1;
        put(k, 1, 0, 0, '0, 1, 0, 0, c, nx);
        put(k, 0, 0, 0, '0, 0, 0, 0, c, nx);
      end
    end
    elen[k] = bn;
  endfunction

  task automatic check(input int k, input int c, input logic [OW-1:0] o);
    int i;
    logic [OW-1:0] e, m;
    i = (c < elen[k]) ? c : elen[k] - 1;
    e = ev[k][i];
    m = em[k][i];
    n_assert++;
    assert ((o & m) === (e & m)) else begin
      n_fail++;
      $error("FAIL %s td%0d cyc%0d observed=%h expected=%h", cur_tag, (k == 0) ? 2 : 1, c, o & m, e & m);
    end
  endtask

  task automatic chk_val(input string tag, input logic [OW-1:0] o, input logic [OW-1:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic run(input logic [AW-1:0] a, input bit go, input int abort_at,
                     input int start2_at, input bit abort_with_start, input int stop_at);
    int lim, idx;
    build(0, 2, a, go, abort_at);
    build(1, 1, a, go, abort_at);
    lim = ((elen[0] > elen[1]) ? elen[0] : elen[1]) + 2;
    if (stop_at >= 0) lim = stop_at;
    for (int c = 0; c < lim; c++) begin
      saddr = (c == start2_at) ? a + AW'(5) : a;
      start = (go && c == 0) || (c == start2_at);
      abort = (c == abort_at) || (abort_with_start && c == 0);
      @(negedge clk);
      check(0, c, obs2);
      check(1, c, obs1);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    if (stop_at < 0) begin
      for (int k = 0; k < 2; k++) begin
        idx = elen[k] - 1;
        hold_cmp[k] = ev[k][idx][17:10];
        hold_nxt[k] = ev[k][idx][9:0];
      end
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    int n, len, ab, s2;
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    for (int k = 0; k < 2; k++) begin
      hold_cmp[k] = '0;
      hold_nxt[k] = '0;
    end
    rom[0] = 16'd3; rom[1] = 16'd2; rom[2] = 16'd4; rom[3] = 16'd1; rom[4] = 16'd2; rom[5] = 16'd3;
    rom[8] = 16'd5; rom[9] = 16'd0;
    rom[16] = 16'd7; rom[17] = 16'd2; rom[18] = 16'd0; rom[19] = 16'd5; rom[20] = 16'd3; rom[21] = 16'd0;
    rom[40] = 16'd6; rom[41] = 16'd1; rom[42] = 16'd1; rom[43] = 16'd6;
    rom[1022] = 16'h0111; rom[1023] = 16'd1;

    #2;
    chk_val("reset_td2", obs2, '0);
    chk_val("reset_td1", obs1, '0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    cur_tag = "basic";       run(10'd0, 1, -1, -1, 0, -1);
    cur_tag = "start_busy";  run(10'd0, 1, -1, 5, 0, -1);
    cur_tag = "n_zero";      run(10'd8, 1, -1, -1, 0, -1);
    cur_tag = "zero_dur";    run(10'd16, 1, -1, -1, 0, -1);
    cur_tag = "abort_on";    run(10'd0, 1, 12, -1, 0, -1);
    cur_tag = "abort_idle";  run(10'd0, 0, 1, -1, 0, -1);
    cur_tag = "start_abort"; run(10'd8, 1, -1, -1, 1, -1);
    cur_tag = "wrap";        run(10'd1022, 1, -1, -1, 0, -1);

    for (int it = 0; it < 6; it++) begin
      a = AW'(100 + it * 60 + $urandom_range(0, 10));
      n = $urandom_range(0, 3);
      rom[a] = 16'($urandom);
      rom[a + AW'(1)] = 16'(n);
      for (int i = 0; i < 2 * n; i++) rom[a + AW'(2 + i)] = 16'($urandom_range(0, 5));
      build(0, 2, a, 1, -1);
      build(1, 1, a, 1, -1);
      len = (elen[0] < elen[1]) ? elen[0] : elen[1];
      ab = -1;
      s2 = -1;
      if ($urandom_range(0, 1) == 0) ab = $urandom_range(1, len - 3);
      else s2 = $urandom_range(1, len - 3);
      cur_tag = $sformatf("rand%0d", it);
      run(a, 1, ab, s2, 0, -1);
    end

    cur_tag = "reset_mid_off";
    run(10'd40, 1, -1, -1, 0, 13);
    chk_val("pre_reset_busy_en", OW'({busy2, busy1, en2, en1}), OW'(4'b1100));
    #2 rst_n = 1'b0;
    #1;
    chk_val("async_reset_td2", obs2, '0);
    chk_val("async_reset_td1", obs1, '0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      hold_cmp[k] = '0;
      hold_nxt[k] = '0;
    end
    @(posedge clk);
    #1;
    cur_tag = "after_reset"; run(10'd0, 0, -1, -1, 0, -1);
    cur_tag = "recover";     run(10'd0, 1, -1, -1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/ir_burst_sequencer.md
Name: ir_burst_sequencer

Overview:
- Sequences one IR code through a pwm_generator carrier source.
- Fetches the code record from a synchronous code ROM: carrier compare value, pair count, then (on, off) duration pairs.
- Programs the PWM compare register, gates PWM enable for each on-time and holds the output low for each off-time.
- Sits between the top-level code-walk logic (start/abort, next address) and the single PWM instance driving the IR LED.

Parameters:
- ADDR_W, 10, code ROM address width.
- DATA_W, 16, ROM word width and duration counter width.
- PWM_W, 8, PWM compare width; must be <= DATA_W.
- TICK_DIV, 12, clocks per duration tick (1 us at 12 MHz); must be >= 1.

Ports:
- clock_in  in  1  system clock.
- reset_n_in  in  1  reset, asynchronous assert, active-low.
- start_in  in  1  single-cycle start request; honoured only in IDLE.
- abort_in  in  1  stop the current code; honoured in any non-IDLE state.
- start_addr_in  in  ADDR_W  address of the code record; sampled with start_in.
- mem_rd_out  out  1  ROM read strobe.
- mem_addr_out  out  ADDR_W  ROM address.
- mem_data_in  in  DATA_W  ROM data, valid the cycle after mem_rd_out.
- pwm_reset_out  out  1  PWM synchronous reset.
- pwm_enable_out  out  1  PWM enable; carrier is emitted while high.
- pwm_forced_out  out  1  PWM forced level; tied 0 (LED off when idle).
- pwm_compare_out  out  PWM_W  PWM compare value.
- pwm_update_out  out  1  PWM compare write strobe.
- busy_out  out  1  high in every state except IDLE.
- done_out  out  1  one-cycle pulse on normal completion.
- next_addr_out  out  ADDR_W  address following the last word of the record; valid when done_out is high and held until the next start.

Behaviour:
- Reset state: every output is 0. The FSM is in IDLE, and all counters and registers are 0.
- Record format, in words from start_addr_in (A):
  - A: carrier compare value (low PWM_W bits used).
  - A+1: pair count N.
  - A+2 onward: on0, off0, on1, off1, ...
  - Durations are in ticks.
- ROM read protocol:
  - Each word takes 2 cycles: an issue cycle (mem_rd_out=1, address driven) and a capture cycle (data registered).
  - mem_rd_out is never high on two consecutive cycles.
- FSM states and transitions:
  - IDLE: on start_in, latch A, assert pwm_reset_out for 1 cycle, go to FETCH_CAR.
  - FETCH_CAR: read A, register the compare value, go to LOAD.
  - LOAD: 1 cycle. pwm_update_out=1, pwm_compare_out=compare, pwm_enable_out=0. Go to FETCH_CNT.
  - FETCH_CNT: read A+1, register N. If N=0, go to DONE; otherwise go to FETCH_ON.
  - FETCH_ON, then FETCH_OFF: read the next two words and register on and off.
  - ON: pwm_enable_out=1 for exactly on×TICK_DIV clocks; if on=0 the state is skipped. Go to OFF.
  - OFF: pwm_enable_out=0 for exactly off×TICK_DIV clocks; if off=0 the state is skipped.
  - After OFF: decrement the remaining-pair count; if it is nonzero go to FETCH_ON, else DONE.
  - DONE: 1 cycle. done_out=1, next_addr_out = A+2+2N (mod 2^ADDR_W), go to IDLE.
- Counters:
  - The tick prescaler and the duration counter restart at entry to each ON and OFF phase, so phase lengths are exact.
  - The 4 fetch cycles between pairs appear as extra enable-low time; the top level compensates in its code tables.
- pwm_compare_out holds the last loaded value outside LOAD. pwm_update_out is high only in LOAD, and only while pwm_enable_out=0.
- Abort:
  - Any non-IDLE state goes to ABORT: 1 cycle, pwm_enable_out=0, pwm_reset_out=1, then IDLE.
  - No done_out pulse; next_addr_out is unchanged.
  - abort_in takes priority over any transition in the same cycle.
  - abort_in in IDLE is ignored; start_in together with abort_in in IDLE starts.
- start_in while busy is ignored.
- Address arithmetic wraps modulo 2^ADDR_W.
- Asynchronous reset mid-code:
  - All outputs drop to 0 immediately; no pwm_reset_out pulse is required.
  - The PWM is left disabled and drives forced 0.

Test Plan:
- Basic code, TICK_DIV=2:
  - ROM[0..5] = {3, 2, 4, 1, 2, 3}, start at A=0.
  - Required: pwm_reset_out pulse, then one LOAD with compare=3.
  - Enable high 8 clocks, low 2 clocks (+4 fetch cycles), high 4, low 6.
  - done_out with next_addr_out=6; busy_out low the cycle after.
- N=0 record: ROM[8..9] = {5, 0}.
  - Required: LOAD compare=5, no enable, done_out with next_addr_out=10.
- Zero durations: pairs (0, 5) and (3, 0) with TICK_DIV=1.
  - Required: the first pair shows no enable-high cycle.
  - The second pair shows enable high exactly 3 clocks; done follows immediately after the fetches.
- Abort during ON at its 3rd clock.
  - Required: next cycle pwm_enable_out=0 and pwm_reset_out=1; following cycle IDLE, busy_out=0, no done_out.
- Start while busy and abort in IDLE.
  - Required: an extra start_in mid-code leaves the timing unchanged.
  - abort_in in IDLE produces no output activity.
- Wrap and reset:
  - Record at A=1022, ADDR_W=10, N=1.
  - Required: ROM addresses 1022, 1023, 0, 1; next_addr_out=2.
  - Asserting reset_n_in low mid-OFF zeros all outputs without waiting for a clock edge.
